// File: rtl/mem_access_stage.sv
// Memory stage: drives the data-memory handshake with byte-lane alignment, stalls
// upstream while a request is outstanding, formats load data and holds MEM/WB.
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  input  logic              in_regwrite,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_mbe,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_pc,
  output logic              wb_trap
);

  typedef enum logic {IDLE, ACCESS} state_t;

  // Access size code: 0 = byte, 1 = half, 2 = word (undefined funct3 falls back to word).
  function automatic logic [1:0] op_size(input logic [2:0] f3, input logic is_load);
    if (f3 == 3'b000 || (is_load && f3 == 3'b100))      return 2'd0;
    else if (f3 == 3'b001 || (is_load && f3 == 3'b101)) return 2'd1;
    else                                                 return 2'd2;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd2 && off != 2'b00) || (sz == 2'd1 && off[0]);
  endfunction

  function automatic logic [3:0] store_mbe(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [1:0] sz,
                                                    input logic [DATA_W-1:0] d);
    case (sz)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{(DATA_W-8){sh[7]}}, sh[7:0]};
      3'b001:  return {{(DATA_W-16){sh[15]}}, sh[15:0]};
      3'b100:  return {{(DATA_W-8){1'b0}}, sh[7:0]};
      3'b101:  return {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        mbe_q, mbe_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              load_q, load_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] wb_pc_q, wb_pc_d;
  logic              wb_trap_q, wb_trap_d;

  logic              mem_op;
  logic [1:0]        in_sz;
  logic              in_mis;

  assign mem_op = in_valid & (in_mem_read | in_mem_write);
  assign in_sz  = op_size(in_funct3, in_mem_read);
  assign in_mis = misaligned(in_sz, in_alu[1:0]);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mbe_d         = mbe_q;
    f3_d          = f3_q;
    rd_d          = rd_q;
    rw_d          = rw_q;
    pc_d          = pc_q;
    load_d        = load_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_trap_d     = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    wb_pc_d       = wb_pc_q;
    stall         = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !in_mis) begin
          state_d = ACCESS;
          stall   = 1'b1;
          addr_d  = in_alu[ADDR_W-1:0];
          wdata_d = store_data(in_sz, in_wdata);
          mbe_d   = in_mem_read ? 4'b1111 : store_mbe(in_sz, in_alu[1:0]);
          f3_d    = in_funct3;
          rd_d    = in_rd;
          rw_d    = in_regwrite;
          pc_d    = in_pc;
          load_d  = in_mem_read;
        end else if (mem_op) begin
          wb_valid_d = 1'b1;
          wb_trap_d  = 1'b1;
          wb_rd_d    = in_rd;
          wb_data_d  = in_alu;
          wb_pc_d    = in_pc;
        end else if (in_valid) begin
          wb_valid_d    = 1'b1;
          wb_regwrite_d = in_regwrite & (in_rd != 5'd0);
          wb_rd_d       = in_rd;
          wb_data_d     = in_alu;
          wb_pc_d       = in_pc;
        end
      end
      ACCESS: begin
        if (dmem_resp) begin
          state_d       = IDLE;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = load_q & rw_q & (rd_q != 5'd0);
          wb_rd_d       = rd_q;
          wb_data_d     = load_q ? load_fmt(f3_q, addr_q[1:0], dmem_rdata) : wdata_q;
          wb_pc_d       = pc_q;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      wb_pc_q       <= '0;
      wb_trap_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      wb_pc_q       <= wb_pc_d;
      wb_trap_q     <= wb_trap_d;
    end
  end

  // Latched operation fields carry no reset; the request strobes are gated by state.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    mbe_q   <= mbe_d;
    f3_q    <= f3_d;
    rd_q    <= rd_d;
    rw_q    <= rw_d;
    pc_q    <= pc_d;
    load_q  <= load_d;
  end

  assign dmem_read   = (state_q == ACCESS) &  load_q;
  assign dmem_write  = (state_q == ACCESS) & ~load_q;
  assign dmem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_wdata  = wdata_q;
  assign dmem_mbe    = (state_q == ACCESS) ? mbe_q : 4'b0000;

  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign wb_pc       = wb_pc_q;
  assign wb_trap     = wb_trap_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: randomized and directed instructions,
// a byte-level memory model, and a decoupled writeback monitor.
module tb_mem_access_stage;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_mem_read = 1'b0, in_mem_write = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_alu = '0, in_wdata = '0, in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic        in_regwrite = 1'b0;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_resp = 1'b0;
  logic        stall, wb_valid, wb_regwrite, wb_trap;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_pc;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_funct3(in_funct3), .in_alu(in_alu),
    .in_wdata(in_wdata), .in_rd(in_rd), .in_regwrite(in_regwrite), .in_pc(in_pc),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall(stall), .wb_valid(wb_valid),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
    .wb_trap(wb_trap)
  );

  typedef struct packed {
    logic        valid, rd, wr;
    logic [2:0]  f3;
    logic [31:0] alu, wdata, pc;
    logic [4:0]  rdst;
    logic        rw;
  } instr_t;

  typedef struct packed {
    logic        trap, rw, chkdata;
    logic [4:0]  rd;
    logic [31:0] data, pc;
  } wbexp_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
  } reqexp_t;

  wbexp_t      wb_q[$];
  reqexp_t     req_q[$];
  logic [31:0] ref_mem[64];
  logic [31:0] dut_mem[64];
  int          checks = 0;
  int          errors = 0;
  int          lat_cfg = 0;
  bit          inject_resp = 1'b0;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  wbexp_t      mon_e;
  reqexp_t     mem_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3, input logic is_load);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd4: return is_load ? 1 : 4;
      3'd5: return is_load ? 2 : 4;
      default: return 4;
    endcase
  endfunction

  function automatic instr_t mk(input logic v, input logic r, input logic w, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] wd,
                                input logic [4:0] rdst, input logic rw, input logic [31:0] pc);
    instr_t t;
    t.valid = v; t.rd = r; t.wr = w; t.f3 = f3; t.alu = alu; t.wdata = wd;
    t.rdst = rdst; t.rw = rw; t.pc = pc;
    return t;
  endfunction

  // Drive one instruction, hold it while stalled, and record what must come out.
  task automatic issue(input instr_t t, input int lat);
    bit memop, is_load;
    int sz, off, n, exp_stall, idx;
    wbexp_t e;
    reqexp_t r;
    logic [31:0] v, word;
    logic [7:0] lb;
    memop   = t.valid && (t.rd || t.wr);
    is_load = t.rd;
    sz      = size_bytes(t.f3, is_load);
    off     = int'(t.alu[1:0]);
    idx     = int'(t.alu[7:2]);
    lat_cfg = lat;
    in_valid = t.valid; in_mem_read = t.rd; in_mem_write = t.wr; in_funct3 = t.f3;
    in_alu = t.alu; in_wdata = t.wdata; in_rd = t.rdst; in_regwrite = t.rw; in_pc = t.pc;
    e.pc = t.pc; e.rd = t.rdst; e.trap = 1'b0; e.chkdata = 1'b1; e.data = t.alu;
    e.rw = t.rw && (t.rdst != 5'd0);
    exp_stall = 0;
    if (memop && (off % sz) != 0) begin
      e.trap = 1'b1; e.rw = 1'b0; e.chkdata = 1'b0;
    end else if (memop) begin
      exp_stall = lat + 1;
      r.wr = !is_load; r.addr = t.alu & 32'hFFFF_FFFC; r.mbe = 4'hF; r.wdata = '0;
      if (is_load) begin
        v = ref_mem[idx] >> (8 * off);
        if (sz == 1) begin
          v = v & 32'hFF;
          if (t.f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
          v = v & 32'hFFFF;
          if (t.f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        e.data = v;
      end else begin
        e.rw = 1'b0; e.chkdata = 1'b0; r.mbe = 4'h0;
        word = ref_mem[idx];
        for (int k = 0; k < 4; k++) begin
          lb = 8'((t.wdata >> (8 * (k % sz))) & 32'hFF);
          r.wdata = r.wdata | (32'(lb) << (8 * k));
          if (k >= off && k < off + sz) begin
            r.mbe[k] = 1'b1;
            word = (word & ~(32'hFF << (8 * k))) | (32'(lb) << (8 * k));
          end
        end
        ref_mem[idx] = word;
      end
      req_q.push_back(r);
    end
    n = 0;
    #3;
    while (stall) begin
      n++;
      if (n > 40) begin
        errors++; checks++;
        $display("FAIL stall_timeout: stall still 1 after %0d cycles", n);
        break;
      end
      @(negedge clk);
      #3;
    end
    if (t.valid) wb_q.push_back(e);
    chk("stall_cycles", n, exp_stall);
    @(negedge clk);
    chk("wb_valid_latency", {31'd0, wb_valid}, {31'd0, t.valid});
  endtask

  // Data memory: responds after lat_cfg extra cycles and checks the lane formatting.
  always @(negedge clk) begin
    dmem_resp  = 1'b0;
    dmem_rdata = $urandom;
    if (inject_resp) begin
      dmem_resp = 1'b1;
    end else if (dmem_read || dmem_write) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = lat_cfg;
      end
      if (mem_cnt == 0) begin
        mem_busy  = 1'b0;
        dmem_resp = 1'b1;
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: addr 0x%08h with no request expected", dmem_addr);
        end else begin
          mem_r = req_q.pop_front();
          chk("req_kind", {30'd0, dmem_read, dmem_write}, mem_r.wr ? 32'd1 : 32'd2);
          chk("req_addr", dmem_addr, mem_r.addr);
          chk("req_mbe", {28'd0, dmem_mbe}, {28'd0, mem_r.mbe});
          if (mem_r.wr) begin
            chk("req_wdata", dmem_wdata, mem_r.wdata);
            for (int k = 0; k < 4; k++)
              if (dmem_mbe[k])
                dut_mem[dmem_addr[7:2]][8*k +: 8] = dmem_wdata[8*k +: 8];
          end else begin
            dmem_rdata = dut_mem[dmem_addr[7:2]];
          end
        end
      end else begin
        mem_cnt--;
      end
    end else begin
      mem_busy = 1'b0;
    end
  end

  // Writeback monitor.
  always @(posedge clk) begin
    #1;
    if (wb_valid) begin
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: wb_pc 0x%08h retired with nothing expected", wb_pc);
      end else begin
        mon_e = wb_q.pop_front();
        chk("wb_pc", wb_pc, mon_e.pc);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
        chk("wb_regwrite", {31'd0, wb_regwrite}, {31'd0, mon_e.rw});
        chk("wb_trap", {31'd0, wb_trap}, {31'd0, mon_e.trap});
        if (mon_e.chkdata) chk("wb_data", wb_data, mon_e.data);
      end
    end
  end

  initial begin
    instr_t t;
    int kind;
    logic [31:0] v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      dut_mem[i] = v;
    end
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
    chk("rst_wb_trap", {31'd0, wb_trap}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_dmem_rw", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("rst_dmem_mbe", {28'd0, dmem_mbe}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(mk(1, 0, 0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1, 32'h0000_0100), 0);
    ref_mem[0] = 32'h80FF_FFFF; dut_mem[0] = 32'h80FF_FFFF;
    issue(mk(1, 1, 0, 3'd0, 32'h0000_1003, 32'h0, 5'd6, 1, 32'h0000_0104), 3);
    ref_mem[0] = 32'hBEEF_0000; dut_mem[0] = 32'hBEEF_0000;
    issue(mk(1, 1, 0, 3'd5, 32'h0000_2002, 32'h0, 5'd7, 1, 32'h0000_0108), 1);
    issue(mk(1, 0, 1, 3'd1, 32'h0000_3002, 32'h0000_CAFE, 5'd8, 1, 32'h0000_010C), 0);
    issue(mk(1, 1, 0, 3'd2, 32'h0000_4001, 32'h0, 5'd9, 1, 32'h0000_0110), 0);
    issue(mk(1, 0, 0, 3'd0, 32'hDEAD_BEEF, 32'h0, 5'd0, 1, 32'h0000_0114), 0);
    issue(mk(1, 1, 0, 3'd2, 32'h0000_3000, 32'h0, 5'd10, 1, 32'h0000_0118), 2);
    issue(mk(0, 1, 0, 3'd2, 32'h0000_0040, 32'h0, 5'd3, 1, 32'h0000_011C), 0);

    // Reset in the middle of an outstanding load, then a stray response.
    lat_cfg = 30;
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'd2;
    in_alu = 32'h0000_0040; in_rd = 5'd4; in_regwrite = 1'b1; in_pc = 32'h0000_0200;
    #3 chk("rst_test_req_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_test_pending_read", {31'd0, dmem_read}, 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_read_drop", {31'd0, dmem_read}, 32'd0);
    chk("rst_async_mbe", {28'd0, dmem_mbe}, 32'd0);
    chk("rst_async_stall", {31'd0, stall}, 32'd0);
    chk("rst_async_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #3 inject_resp = 1'b1;
    @(negedge clk);
    #3 chk("stray_resp_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #2;
    chk("stray_resp_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("stray_resp_no_req", {30'd0, dmem_read, dmem_write}, 32'd0);
    inject_resp = 1'b0;
    @(negedge clk);
    issue(mk(1, 0, 0, 3'd0, 32'h0000_5678, 32'h0, 5'd11, 1, 32'h0000_0204), 0);

    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 9);
      t = mk(kind != 0, 1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
      if (kind == 0) begin
        t.rd = 1'($urandom_range(0, 1));
        t.wr = 1'($urandom_range(0, 1));
      end else if (kind >= 4 && kind <= 6) begin
        t.rd = 1'b1;
      end else if (kind >= 7) begin
        t.wr = 1'b1;
      end
      issue(t, $urandom_range(0, 3));
    end

    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain_wb_queue", wb_q.size(), 32'd0);
    chk("drain_req_queue", req_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory stage between the EX/MEM register and the register-file writeback. It consumes the EX/MEM outputs (control fields, ALU result, store data), runs the data-memory handshake with byte-lane alignment, and stalls the pipeline while a request is outstanding. It formats load data (shift plus sign/zero extension), selects the writeback value, and holds the result in an internal MEM/WB register.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; byte lanes = 4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  EX/MEM holds a live instruction
in_mem_read  in  1  instruction is a load
in_mem_write  in  1  instruction is a store
in_funct3  in  3  RV32I width/sign code (lb/lh/lw/lbu/lhu, sb/sh/sw)
in_alu  in  32  ALU result; effective address for memory ops
in_wdata  in  32  store data (rs2)
in_rd  in  5  destination register
in_regwrite  in  1  instruction writes rd
in_pc  in  32  instruction PC
dmem_read  out  1  data-memory read request
dmem_write  out  1  data-memory write request
dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
dmem_wdata  out  32  lane-shifted store data
dmem_mbe  out  4  byte enables
dmem_rdata  in  32  read data
dmem_resp  in  1  access complete, one-cycle pulse
stall  out  1  hold EX/MEM and all upstream stages
wb_valid  out  1  MEM/WB holds a live instruction
wb_regwrite  out  1  write rd this cycle
wb_rd  out  5  destination
wb_data  out  32  writeback value
wb_pc  out  32  PC of the retiring instruction
wb_trap  out  1  misaligned access detected

Behaviour:
- Reset (async, any state): FSM goes to IDLE. All wb_* outputs, dmem_read, dmem_write, and dmem_mbe go to 0. The outstanding request is dropped, and any late dmem_resp is ignored while in IDLE.
- FSM states: IDLE, ACCESS.
- Memory op definition: mem_op = in_valid & (in_mem_read | in_mem_write).
- Misalignment rules:
  - Word op: misaligned when addr[1:0] != 0.
  - Half op: misaligned when addr[0] != 0.
  - Byte op: never misaligned.
- IDLE, mem_op and aligned:
  - Latch addr, shifted wdata, mbe, funct3, rd, regwrite, pc, and read/write kind.
  - Go to ACCESS; stall=1 this cycle.
  - MEM/WB loads a bubble (wb_valid=0, wb_regwrite=0).
- IDLE, mem_op and misaligned:
  - No request is issued; stall=0.
  - MEM/WB loads wb_valid=1, wb_trap=1, wb_regwrite=0, wb_pc=in_pc.
- IDLE, non-memory in_valid:
  - stall=0.
  - MEM/WB loads wb_data=in_alu, wb_regwrite=in_regwrite, wb_trap=0. Latency is 1 cycle.
- IDLE, in_valid=0: MEM/WB loads a bubble.
- ACCESS:
  - dmem_read or dmem_write is held at 1 from latched registers. Address, data, and mbe are stable until dmem_resp.
  - While dmem_resp=0: stall=1 and MEM/WB loads bubbles.
  - On dmem_resp=1: stall=0 that same cycle so upstream advances. MEM/WB loads the completed op and the FSM returns to IDLE.
  - Loads write formatted data with wb_regwrite=latched regwrite. Stores retire with wb_regwrite=0.
  - Minimum memory-op latency is 2 cycles (request cycle, then response cycle).
- Store lane formatting:
  - sb: mbe=4'b0001<<addr[1:0]; wdata replicated to byte lanes.
  - sh: mbe=4'b0011<<{addr[1],1'b0}; halfword replicated.
  - sw: mbe=4'b1111.
  - Loads use mbe=4'b1111.
- Load formatting:
  - Shift: sh = dmem_rdata >> (8*addr[1:0]).
  - lb/lh sign-extend bit 7/15 of sh; lbu/lhu zero-extend; lw passes the word.
  - Undefined funct3 values are handled as lw/sw.
- Writes to x0: wb_regwrite is forced to 0 when rd=0.
- At most one outstanding request. Inputs are ignored in ACCESS; upstream is stalled, so they equal the latched op.

Test Plan:
- ALU op in_alu=0x1234, rd=5, regwrite=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, stall never asserted.
- lb at addr 0x1003, resp after 3 ACCESS cycles with rdata=0x80FFFFFF -> dmem_addr=0x1000; stall=1 for 4 cycles; wb_data=0xFFFFFF80.
- lhu at addr 0x2002, rdata=0xBEEF0000 -> wb_data=0x0000BEEF.
- sh at addr 0x3002, rs2=0x0000CAFE -> dmem_write=1, mbe=4'b1100, wdata[31:16]=0xCAFE; wb_regwrite=0.
- lw at addr 0x4001 -> no dmem request, stall=0, wb_trap=1, wb_regwrite=0.
- Reset asserted mid-ACCESS -> dmem_read drops to 0 immediately. A subsequent dmem_resp is ignored. The next ALU op retires normally.
